// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequences one pe tile job per start pulse.
//   Order: load weight, switch it active, stream cfg_len samples with a fixed psum bias, collect results.
//   Ports: start/cfg_* from the scheduler, in_valid/in_ready/in_data input stream,
//   pe_* drives and observes the pe datapath, res_*/busy/done/err report job progress.
//   All outputs are registered except in_ready.
module pe_seq_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int LEN_WIDTH     = 8,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] cfg_weight,
  input  logic [DATA_WIDTH-1:0] cfg_psum,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  pe_enabled,
  output logic [DATA_WIDTH-1:0] pe_weight_in,
  output logic                  pe_accept_w_in,
  output logic                  pe_switch_in,
  output logic [DATA_WIDTH-1:0] pe_input_in,
  output logic [DATA_WIDTH-1:0] pe_psum_in,
  output logic                  pe_valid_in,
  input  logic [DATA_WIDTH-1:0] pe_psum_out,
  input  logic                  pe_valid_out,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [LEN_WIDTH-1:0]  res_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_SWITCH,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] psum_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic [DCW-1:0]        drain_cnt;
  logic                  beat;
  logic                  collecting;

  assign in_ready   = (state == S_STREAM) && (issued < len_q);
  assign beat       = in_valid && in_ready;
  assign collecting = (state == S_STREAM) || (state == S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      psum_q         <= '0;
      len_q          <= '0;
      issued         <= '0;
      drain_cnt      <= '0;
      pe_enabled     <= 1'b0;
      pe_weight_in   <= '0;
      pe_accept_w_in <= 1'b0;
      pe_switch_in   <= 1'b0;
      pe_input_in    <= '0;
      pe_psum_in     <= '0;
      pe_valid_in    <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_count      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them below.
      pe_accept_w_in <= 1'b0;
      pe_switch_in   <= 1'b0;
      pe_valid_in    <= 1'b0;
      res_valid      <= 1'b0;
      done           <= 1'b0;

      // Results are only meaningful while a job has samples in flight.
      if (collecting && pe_valid_out) begin
        res_valid <= 1'b1;
        res_data  <= pe_psum_out;
        if (res_count != len_q) begin
          res_count <= res_count + LEN_WIDTH'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_LOAD_W;
            pe_weight_in   <= cfg_weight;  // doubles as the job's weight register
            psum_q         <= cfg_psum;
            len_q          <= cfg_len;
            issued         <= '0;
            res_count      <= '0;
            err            <= 1'b0;
            pe_accept_w_in <= 1'b1;
            pe_enabled     <= 1'b1;
            busy           <= 1'b1;
          end
        end

        S_LOAD_W: begin
          state        <= S_SWITCH;
          pe_switch_in <= 1'b1;
        end

        S_SWITCH: begin
          if (len_q == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (beat) begin
            pe_input_in <= in_data;
            pe_psum_in  <= psum_q;
            pe_valid_in <= 1'b1;
            issued      <= issued + LEN_WIDTH'(1);
            if (issued + LEN_WIDTH'(1) == len_q) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end
        end

        S_DRAIN: begin
          // drain_cnt counts completed DRAIN cycles; the last allowed one ends the job with err.
          if (res_count == len_q) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (drain_cnt == DCW'(DRAIN_TIMEOUT - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end

        S_DONE: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          pe_enabled <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: directed bench for pe_seq_ctrl with a small Q8.8 pe model.
//   The model latches the weight on accept_w, activates it on switch and returns
//   psum + weight*input one cycle after each pe_valid_in (unless disabled).
module tb_pe_seq_ctrl;
  localparam int DW = 16;
  localparam int LW = 8;
  localparam int DT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] cfg_weight, cfg_psum;
  logic [LW-1:0] cfg_len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          pe_enabled;
  logic [DW-1:0] pe_weight_in;
  logic          pe_accept_w_in, pe_switch_in;
  logic [DW-1:0] pe_input_in, pe_psum_in;
  logic          pe_valid_in;
  logic [DW-1:0] pe_psum_out;
  logic          pe_valid_out;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [LW-1:0] res_count;
  logic          busy, done, err;

  always #5 clk = ~clk;

  pe_seq_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .DRAIN_TIMEOUT(DT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_weight(cfg_weight), .cfg_psum(cfg_psum), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pe_enabled(pe_enabled), .pe_weight_in(pe_weight_in),
    .pe_accept_w_in(pe_accept_w_in), .pe_switch_in(pe_switch_in),
    .pe_input_in(pe_input_in), .pe_psum_in(pe_psum_in), .pe_valid_in(pe_valid_in),
    .pe_psum_out(pe_psum_out), .pe_valid_out(pe_valid_out),
    .res_valid(res_valid), .res_data(res_data), .res_count(res_count),
    .busy(busy), .done(done), .err(err)
  );

  // pe model
  logic               model_en;
  logic [DW-1:0]      w_shadow, w_act;
  logic signed [31:0] prod;
  assign prod = $signed(w_act) * $signed(pe_input_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_shadow     <= '0;
      w_act        <= '0;
      pe_valid_out <= 1'b0;
      pe_psum_out  <= '0;
    end else begin
      if (pe_accept_w_in) w_shadow <= pe_weight_in;
      if (pe_switch_in)   w_act    <= w_shadow;
      pe_valid_out <= pe_valid_in && model_en;
      pe_psum_out  <= pe_psum_in + prod[23:8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [95:0] all_outs();
    return {in_ready, pe_enabled, pe_weight_in, pe_accept_w_in, pe_switch_in,
            pe_input_in, pe_psum_in, pe_valid_in, res_valid, res_data, res_count,
            busy, done, err};
  endfunction

  // Per-job observations
  logic          acc1, acc2, sw1, sw2, en1, busy1, err1;
  logic [DW-1:0] wseen, pin_last, pps_last, res_last, res_sum;
  logic [31:0]   ir_hist, pv_hist;
  int            done_k, done_cnt, rv_cnt;
  logic          busy_after, err_end;
  logic [LW-1:0] cnt_end;

  // Cycle k=0 is the one after edge T+2; pat[k] drives in_valid for the edge ending cycle k.
  task automatic run_job(input logic [DW-1:0] w, input logic [DW-1:0] p, input logic [LW-1:0] len,
                         input logic [15:0] pat, input logic [DW-1:0] base, input logic [DW-1:0] stp,
                         input int start_k, input int budget);
    cfg_weight = w; cfg_psum = p; cfg_len = len; start = 1'b1; in_valid = 1'b0;
    step();
    start = 1'b0;
    acc1 = pe_accept_w_in; sw1 = pe_switch_in; wseen = pe_weight_in;
    en1 = pe_enabled; busy1 = busy; err1 = err;
    step();
    acc2 = pe_accept_w_in; sw2 = pe_switch_in;
    step();
    ir_hist = '0; pv_hist = '0; done_k = -1; done_cnt = 0; rv_cnt = 0;
    res_sum = '0; res_last = '0; pin_last = '0; pps_last = '0; busy_after = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (k < 32) begin
        ir_hist[k] = in_ready;
        pv_hist[k] = pe_valid_in;
      end
      if (pe_valid_in) begin pin_last = pe_input_in; pps_last = pe_psum_in; end
      if (res_valid) begin rv_cnt++; res_last = res_data; res_sum = res_sum + res_data; end
      if (done) begin done_cnt++; if (done_k < 0) done_k = k; end
      if (done_k >= 0 && k == done_k + 1) begin
        busy_after = busy;
        break;
      end
      in_valid = (k < 16) ? pat[k] : 1'b0;
      in_data  = base + stp * 16'(k);
      start    = (k == start_k);
      if (start) begin cfg_weight = 16'h1234; cfg_psum = 16'h5555; cfg_len = 8'd9; end
      step();
    end
    in_valid = 1'b0; start = 1'b0;
    err_end = err; cnt_end = res_count;
    check("job_done_seen", (done_k >= 0), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_weight = '0; cfg_psum = '0; cfg_len = '0;
    in_valid = 1'b0; in_data = '0; model_en = 1'b1;
    step(); step();
    check("reset_outs", all_outs(), '0);
    rst = 1'b0;
    step();
    check("idle_outs", all_outs(), '0);

    // 1: basic job
    run_job(16'h0200, 16'h0100, 8'd1, 16'h0001, 16'h0300, 16'h0000, -1, 100);
    check("t1_acc_w", {acc1, acc2}, 2'b10);
    check("t1_switch", {sw1, sw2}, 2'b01);
    check("t1_weight", wseen, 16'h0200);
    check("t1_en_busy", {en1, busy1}, 2'b11);
    check("t1_pv_hist", pv_hist, 32'h2);
    check("t1_pe_in", {pin_last, pps_last}, {16'h0300, 16'h0100});
    check("t1_res", res_last, 16'h0700);
    check("t1_cnt", cnt_end, 8'd1);
    check("t1_done", {done_cnt[3:0], done_k[7:0]}, {4'd1, 8'd4});
    check("t1_err_busy", {err_end, busy_after, pe_enabled}, 3'b000);

    // 2: len=4, in_valid held high
    run_job(16'h0080, 16'h0040, 8'd4, 16'hFFFF, 16'h0100, 16'h0100, -1, 100);
    check("t2_ir_hist", ir_hist, 32'h0000000F);
    check("t2_pv_hist", pv_hist, 32'h0000001E);
    check("t2_rv", rv_cnt, 4);
    check("t2_res", {res_last, res_sum}, {16'h0240, 16'h0600});
    check("t2_cnt", cnt_end, 8'd4);

    // 3: len=3 with bubbles 1,0,1,0,1
    run_job(16'hFF00, 16'h0200, 8'd3, 16'h0015, 16'h0100, 16'h0100, -1, 100);
    check("t3_ir_hist", ir_hist, 32'h0000001F);
    check("t3_pv_hist", pv_hist, 32'h0000002A);
    check("t3_res", {res_last, res_sum}, {16'hFD00, 16'hFD00});
    check("t3_rv_cnt", {rv_cnt[7:0], cnt_end}, {8'd3, 8'd3});

    // 4: len=0
    run_job(16'h0100, 16'h0000, 8'd0, 16'hFFFF, 16'h0100, 16'h0000, -1, 20);
    check("t4_done_k", done_k, 0);
    check("t4_no_pv", {pv_hist, ir_hist}, '0);
    check("t4_cnt_rv", {cnt_end, rv_cnt[7:0]}, '0);
    check("t4_busy", {done_cnt[3:0], busy_after}, {4'd1, 1'b0});

    // 5: pe never answers -> drain timeout; start while busy is ignored
    model_en = 1'b0;
    run_job(16'h0100, 16'h0000, 8'd2, 16'hFFFF, 16'h0100, 16'h0000, 10, 100);
    check("t5_done_k", done_k, DT + 2);
    check("t5_err", err_end, 1'b1);
    check("t5_cnt", {cnt_end, rv_cnt[7:0]}, '0);
    check("t5_pv_hist", pv_hist, 32'h6);
    step(); step(); step();
    check("t5_err_hold", {err, busy, done}, 3'b100);
    model_en = 1'b1;
    run_job(16'h0200, 16'h0100, 8'd1, 16'h0001, 16'h0300, 16'h0000, -1, 100);
    check("t5_err_clear", {err1, err_end}, 2'b00);
    check("t5_res", res_last, 16'h0700);

    // 6: reset mid-STREAM between edges
    cfg_weight = 16'h0200; cfg_psum = 16'h0100; cfg_len = 8'd4; start = 1'b1;
    step(); start = 1'b0; step(); step();
    in_valid = 1'b1; in_data = 16'h0300;
    step(); step();
    check("t6_streaming", {pe_valid_in, busy}, 2'b11);
    #2 rst = 1'b1;
    #1 check("t6_rst_outs", all_outs(), '0);
    in_valid = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) done_cnt++;
    end
    rst = 1'b0;
    step();
    if (done) done_cnt++;
    check("t6_no_done", done_cnt, 0);
    check("t6_idle_outs", all_outs(), '0);
    run_job(16'h0200, 16'h0100, 8'd1, 16'h0001, 16'h0300, 16'h0000, -1, 100);
    check("t6_fresh_job", {res_last, cnt_end, err_end}, {16'h0700, 8'd1, 1'b0});
    check("t6_fresh_done", {done_cnt[3:0], busy_after}, {4'd1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
